fp4_fft_unloader: RTL

FP4_FFT_UNLOADER -- requirements
Module: fp4_fft_unloader

---
 rtl/fp4_fft_unloader.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp4_fft_unloader.sv
// fp4_fft_unloader
// Streams the results of an FFT out of its result memory once the core
// reports completion. Samples are read in natural bin order through a
// synchronous read port (one cycle of read latency), buffered in a small
// FIFO, and presented on a valid/ready stream through a registered output
// stage.
//
// Ports
//   clk          single clock, all state on the rising edge
//   rst          asynchronous, active-low reset
//   fft_done     one-cycle pulse from the FFT core, accepted only in IDLE
//   n_log2       log2 of the transform size, sampled with an accepted fft_done
//   rd_req       this block owns the memory read port this cycle
//   rd_addr      memory read address (0 outside READ)
//   rd_data      FP4 complex sample {re[7:4], im[3:0]}, one cycle after rd_req
//   m_valid      stream sample valid
//   m_ready      downstream accepts the sample
//   m_data       stream sample
//   m_index      frequency bin of m_data
//   m_last       high together with bin N-1
//   busy         unload in progress (READ, DRAIN, DONE)
//   unload_done  one-cycle pulse after the final transfer
module fp4_fft_unloader #(
    parameter int MAX_N      = 32,
    parameter int ADDR_WIDTH = $clog2(MAX_N),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fft_done,
    input  logic [2:0]            n_log2,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [7:0]            m_data,
    output logic [ADDR_WIDTH-1:0] m_index,
    output logic                  m_last,
    output logic                  busy,
    output logic                  unload_done
);

    localparam int LOG2_MAX = $clog2(MAX_N);
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1) + 1;

    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0]      PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Highest bin index N-1 for N = 2^min(k, log2(MAX_N)): a mask of k ones.
    function automatic logic [ADDR_WIDTH-1:0] last_index(input logic [2:0] k);
        logic [2:0] kc;
        if (int'(k) > LOG2_MAX) begin
            kc = 3'(LOG2_MAX);
        end else begin
            kc = k;
        end
        return ~({ADDR_WIDTH{1'b1}} << kc);
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] last_idx_r;
    logic [ADDR_WIDTH-1:0] rd_cnt_r;
    logic                  p1_valid_r;
    logic [ADDR_WIDTH-1:0] p1_addr_r;
    logic [7:0]            fifo_data_r [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_idx_r  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      fifo_cnt_r;
    logic                  out_valid_r;
    logic [7:0]            out_data_r;
    logic [ADDR_WIDTH-1:0] out_idx_r;
    logic                  out_last_r;
    logic                  done_r;

    logic [CNT_W-1:0]      occ_s;
    logic                  start_s;
    logic                  issue_s;
    logic                  push_s;
    logic                  load_s;
    logic                  xfer_s;
    logic                  last_xfer_s;

    // Handshake and flow-control decode. The output register counts as one
    // buffer slot, and a read still in the memory pipeline reserves another,
    // so a read is issued only if every sample in the system has a home.
    always_comb begin
        occ_s       = fifo_cnt_r + CNT_W'(out_valid_r) + CNT_W'(p1_valid_r);
        start_s     = (state_r == IDLE) && fft_done;
        issue_s     = (state_r == READ) && (occ_s < DEPTH_C);
        push_s      = p1_valid_r;
        xfer_s      = out_valid_r && m_ready;
        load_s      = (fifo_cnt_r != CNT_ZERO) && (!out_valid_r || m_ready);
        last_xfer_s = xfer_s && out_last_r;
    end

    // Next-state logic of the unload sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (issue_s && (rd_cnt_r == last_idx_r)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if (last_xfer_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latched transform size and read address counter; the counter parks on
    // N-1 rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_idx_r <= ADDR_ZERO;
            rd_cnt_r   <= ADDR_ZERO;
        end else if (start_s) begin
            last_idx_r <= last_index(n_log2);
            rd_cnt_r   <= ADDR_ZERO;
        end else if (issue_s && (rd_cnt_r != last_idx_r)) begin
            rd_cnt_r   <= rd_cnt_r + ADDR_ONE;
        end else begin
            rd_cnt_r   <= rd_cnt_r;
        end
    end

    // Tracks the read in flight so its returning data can be tagged with its bin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_valid_r <= 1'b0;
            p1_addr_r  <= ADDR_ZERO;
        end else begin
            p1_valid_r <= issue_s;
            p1_addr_r  <= rd_cnt_r;
        end
    end

    // FIFO storage, written with the returning memory data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_r[i] <= 8'h00;
                fifo_idx_r[i]  <= ADDR_ZERO;
            end
        end else if (push_s) begin
            fifo_data_r[wr_ptr_r] <= rd_data;
            fifo_idx_r[wr_ptr_r]  <= p1_addr_r;
        end else begin
            fifo_data_r[wr_ptr_r] <= fifo_data_r[wr_ptr_r];
            fifo_idx_r[wr_ptr_r]  <= fifo_idx_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; explicit wrap supports non-power-of-two depths.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            fifo_cnt_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (load_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, load_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Registered stream stage: refills from the FIFO whenever it is empty or
    // being emptied, and otherwise holds its contents through a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_idx_r   <= ADDR_ZERO;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= fifo_data_r[rd_ptr_r];
            out_idx_r   <= fifo_idx_r[rd_ptr_r];
            out_last_r  <= (fifo_idx_r[rd_ptr_r] == last_idx_r);
        end else if (xfer_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

    // Completion pulse, high for the DONE cycle that follows the last transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_xfer_s;
        end
    end

    assign rd_req      = issue_s;
    assign rd_addr     = (state_r == READ) ? rd_cnt_r : ADDR_ZERO;
    assign m_valid     = out_valid_r;
    assign m_data      = out_data_r;
    assign m_index     = out_idx_r;
    assign m_last      = out_last_r;
    assign busy        = (state_r != IDLE);
    assign unload_done = done_r;

endmodule
